// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: tracks oversample edge and bit position, sequences
// the sampler/deserializer/checker enables and reports per-frame results.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_counter,
  output logic [3:0] bit_counter,
  output logic       data_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       par_error,
  output logic       frame_error
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  state_t     state;
  logic [5:0] last_edge;
  logic       par_en_q;
  logic       perr;
  logic [5:0] last_dec;
  logic       bit_end;

  // Unsupported oversampling ratios fall back to 8 ticks per bit.
  always_comb begin
    last_dec = 6'd7;
    case (Prescale)
      6'd16:   last_dec = 6'd15;
      6'd32:   last_dec = 6'd31;
      default: last_dec = 6'd7;
    endcase
  end

  assign bit_end      = (state != IDLE) && (edge_counter == last_edge);
  assign data_samp_en = (state != IDLE);
  assign strt_chk_en  = (state == START);
  assign par_chk_en   = (state == PARITY);
  assign stp_chk_en   = (state == STOP);
  assign deser_en     = (state == DATA) && bit_end;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      edge_counter <= '0;
      bit_counter  <= '0;
      last_edge    <= 6'd7;
      par_en_q     <= 1'b0;
      perr         <= 1'b0;
      data_valid   <= 1'b0;
      par_error    <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      par_error   <= 1'b0;
      frame_error <= 1'b0;
      if (state != IDLE)
        edge_counter <= bit_end ? 6'd0 : edge_counter + 6'd1;
      case (state)
        IDLE: begin
          // Frame format is latched here and held until the frame completes.
          if (!RX_IN) begin
            state        <= START;
            edge_counter <= '0;
            bit_counter  <= '0;
            last_edge    <= last_dec;
            par_en_q     <= PAR_EN;
            perr         <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            if (strt_glitch) begin
              state       <= IDLE;
              bit_counter <= '0;
            end else begin
              state       <= DATA;
              bit_counter <= bit_counter + 4'd1;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_counter <= bit_counter + 4'd1;
            if (bit_counter == LAST_DATA_BIT)
              state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_end) begin
            perr        <= par_err;
            bit_counter <= bit_counter + 4'd1;
            state       <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            state       <= IDLE;
            bit_counter <= '0;
            data_valid  <= ~perr & ~stp_err;
            par_error   <= perr;
            frame_error <= stp_err;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: directed frames against a frame-timing model that
// derives expected outputs from elapsed cycles since the start-bit entry.
module tb_uart_rx_fsm;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [5:0] edge_counter;
  logic [3:0] bit_counter;
  logic       data_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, par_error, frame_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int deser_cnt = 0, dv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int first_deser = -1, last_deser = -1, pulse_cyc = -1;

  // Frame-level model state
  int m_active = 0, m_t = 0, m_p = 8, m_par = 0, m_perr = 0;
  int m_dv = 0, m_pe = 0, m_fe = 0;

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK(clk), .RST(rst_n), .RX_IN(rx_in), .PAR_EN(par_en), .Prescale(prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_counter(edge_counter), .bit_counter(bit_counter),
    .data_samp_en(data_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
    .par_error(par_error), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ticks_of(input int ps);
    case (ps)
      16:      return 16;
      32:      return 32;
      default: return 8;
    endcase
  endfunction

  // Model advances one oversample tick per clock; bit position is t/P.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_t = 0; m_perr = 0;
      m_dv = 0; m_pe = 0; m_fe = 0;
    end else begin
      int b, nb;
      m_dv = 0; m_pe = 0; m_fe = 0;
      if (m_active == 0) begin
        if (rx_in == 1'b0) begin
          m_active = 1; m_t = 0; m_p = ticks_of(int'(prescale));
          m_par = int'(par_en); m_perr = 0;
        end
      end else begin
        b  = m_t / m_p;
        nb = DW + 2 + m_par;
        if ((m_t % m_p) == m_p - 1) begin
          if (b == 0 && strt_glitch) m_active = 0;
          else if (m_par == 1 && b == DW + 1) m_perr = int'(par_err);
          else if (b == nb - 1) begin
            m_active = 0;
            m_dv = (m_perr == 0 && !stp_err) ? 1 : 0;
            m_pe = m_perr;
            m_fe = int'(stp_err);
          end
        end
        m_t++;
      end
    end
  end

  function automatic logic [17:0] out_vec();
    return {edge_counter, bit_counter, data_samp_en, deser_en, strt_chk_en,
            par_chk_en, stp_chk_en, data_valid, par_error, frame_error};
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  // Every-cycle compare of the full output vector against the model.
  always @(negedge clk) begin
    logic [17:0] exp_v;
    int b, e, nb;
    exp_v = '0;
    if (m_active != 0) begin
      b  = m_t / m_p;
      e  = m_t % m_p;
      nb = DW + 2 + m_par;
      exp_v[17:12] = 6'(e);
      exp_v[11:8]  = 4'(b);
      exp_v[7]     = 1'b1;
      exp_v[6]     = (b >= 1 && b <= DW && e == m_p - 1);
      exp_v[5]     = (b == 0);
      exp_v[4]     = (m_par == 1 && b == DW + 1);
      exp_v[3]     = (b == nb - 1);
    end
    exp_v[2] = (m_dv != 0);
    exp_v[1] = (m_pe != 0);
    exp_v[0] = (m_fe != 0);
    checks++;
    if (out_vec() !== exp_v) begin
      errors++;
      $display("[TB] FAIL cycle_compare @%0d: got 0x%05h expected 0x%05h", cyc, out_vec(), exp_v);
    end
    if (deser_en) begin
      deser_cnt++;
      if (first_deser < 0) first_deser = cyc;
      last_deser = cyc;
    end
    if (data_valid)  begin dv_cnt++; pulse_cyc = cyc; end
    if (par_error)   begin pe_cnt++; pulse_cyc = cyc; end
    if (frame_error) begin fe_cnt++; pulse_cyc = cyc; end
  end

  task automatic idle_cycles(input int n);
    rx_in = 1'b1; strt_glitch = 1'b1; par_err = 1'b1; stp_err = 1'b1;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Drives one frame tick by tick; checker inputs carry the wanted value only
  // on the final tick of their bit and the opposite value elsewhere.
  task automatic apply_stimulus(input int presc, input bit par, input logic [7:0] data,
                                input bit pe, input bit se, input bit glitch,
                                input int change_at, input int abort_at);
    int p, nb, n, b, e;
    p  = ticks_of(presc);
    nb = DW + 2 + int'(par);
    n  = glitch ? p : nb * p;
    rx_in = 1'b0; prescale = 6'(presc); par_en = par;
    @(posedge clk); #2;
    start_cyc = cyc;
    deser_cnt = 0; dv_cnt = 0; pe_cnt = 0; fe_cnt = 0;
    first_deser = -1; last_deser = -1; pulse_cyc = -1;
    for (int k = 0; k < n; k++) begin
      b = k / p;
      e = k % p;
      if (b == 0)                  rx_in = (glitch && k >= 2);
      else if (b <= DW)            rx_in = data[b-1];
      else if (par && b == DW + 1) rx_in = ^data;
      else                         rx_in = 1'b1;
      strt_glitch = (b == 0) ? ((e == p - 1) ? glitch : ~glitch) : 1'b1;
      par_err     = (par && b == DW + 1) ? ((e == p - 1) ? pe : ~pe) : 1'b1;
      stp_err     = (b == nb - 1) ? ((e == p - 1) ? se : ~se) : 1'b1;
      if (k == change_at) begin prescale = 6'd16; par_en = ~par; end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_output("reset_async_outputs", int'(out_vec()), 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    rx_in = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] uart_rx_fsm bench start");
    repeat (3) @(posedge clk);
    #2;
    check_output("reset_outputs", int'(out_vec()), 0);
    rst_n = 1'b1;
    idle_cycles(3);

    apply_stimulus(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, -1);
    idle_cycles(3);
    check_output("p8_deser_count", deser_cnt, 8);
    check_output("p8_deser_span", last_deser - first_deser, 56);
    check_output("p8_dv_count", dv_cnt, 1);
    check_output("p8_dv_delay", pulse_cyc - start_cyc, 80);
    check_output("p8_err_pulses", pe_cnt + fe_cnt, 0);

    apply_stimulus(16, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, -1, -1);
    idle_cycles(3);
    check_output("p16_par_error_count", pe_cnt, 1);
    check_output("p16_dv_count", dv_cnt, 0);
    check_output("p16_pulse_delay", pulse_cyc - start_cyc, 176);

    apply_stimulus(32, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, -1, -1);
    idle_cycles(3);
    check_output("p32_frame_error_count", fe_cnt, 1);
    check_output("p32_dv_count", dv_cnt, 0);
    apply_stimulus(32, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, -1, -1);
    idle_cycles(3);
    check_output("p32_clean_dv_count", dv_cnt, 1);
    check_output("p32_clean_dv_delay", pulse_cyc - start_cyc, 320);

    apply_stimulus(8, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, -1, -1);
    #3;
    check_output("glitch_back_in_idle", int'({strt_chk_en, data_samp_en, edge_counter, bit_counter}), 0);
    idle_cycles(4);
    check_output("glitch_deser_count", deser_cnt, 0);
    check_output("glitch_pulses", dv_cnt + pe_cnt + fe_cnt, 0);

    apply_stimulus(5, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 20, -1);
    idle_cycles(3);
    check_output("illegal_ps_dv_delay", pulse_cyc - start_cyc, 80);
    check_output("illegal_ps_deser_span", last_deser - first_deser, 56);

    apply_stimulus(8, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, -1, 35);
    idle_cycles(3);
    check_output("abort_pulses", dv_cnt + pe_cnt + fe_cnt, 0);
    apply_stimulus(16, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, -1, -1);
    idle_cycles(3);
    check_output("post_reset_dv_count", dv_cnt, 1);

    apply_stimulus(8, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, -1);
    apply_stimulus(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, -1, -1);
    idle_cycles(3);
    check_output("b2b_dv_count", dv_cnt, 1);
    check_output("b2b_dv_delay", pulse_cyc - start_cyc, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Control stage of the UART receiver. Sits upstream of the data sampler, deserializer and the start, parity and stop checkers.
- Tracks the oversampled edge and bit position within a frame and sequences the enables for those checkers.
- Consumes the checker results and issues a one-cycle data_valid for each error-free frame, plus error pulses for bad frames.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..8).

Ports:
- CLK  input  1  oversampling clock.
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line, already synchronised; idle high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- Prescale  input  6  oversampling ratio; legal values 8, 16, 32; any other value is treated as 8.
- strt_glitch  input  1  from start check; valid when strt_chk_en=1.
- par_err  input  1  from parity check; valid when par_chk_en=1.
- stp_err  input  1  from stop check; valid when stp_chk_en=1.
- edge_counter  output  6  oversample tick index within the current bit.
- bit_counter  output  4  bit index within the frame.
- data_samp_en  output  1  sampler enable.
- deser_en  output  1  deserializer shift strobe.
- strt_chk_en  output  1  start-check enable.
- par_chk_en  output  1  parity-check enable.
- stp_chk_en  output  1  stop-check enable.
- data_valid  output  1  one-cycle pulse: frame received with no errors.
- par_error  output  1  one-cycle pulse: parity failure.
- frame_error  output  1  one-cycle pulse: stop-bit failure.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE. All outputs and counters are 0.
- LAST = decoded Prescale - 1 (7, 15 or 31).
- Bit end is the cycle where edge_counter==LAST.
- Edge and bit counters:
  - Both run only outside IDLE.
  - edge_counter increments each cycle and wraps to 0 at bit end.
  - bit_counter increments at bit end.
  - Both are cleared on every entry to IDLE.
- Bit numbering: 0 = start; 1..DATA_WIDTH = data; DATA_WIDTH+1 = parity (only when PAR_EN=1); the next index = stop.
- IDLE: if RX_IN==0, go to START next cycle with edge_counter=0 and bit_counter=0.
- START:
  - strt_chk_en=1 and data_samp_en=1.
  - At bit end: if strt_glitch=1, go to IDLE with no output pulses; otherwise go to DATA.
- DATA:
  - data_samp_en=1.
  - deser_en pulses for exactly one cycle at each bit end, giving DATA_WIDTH strobes per frame.
  - At the bit end of bit DATA_WIDTH: go to PARITY if PAR_EN=1, else STOP.
- PARITY:
  - data_samp_en=1 and par_chk_en=1.
  - At bit end, par_err is captured into an internal flag; go to STOP.
- STOP:
  - data_samp_en=1 and stp_chk_en=1.
  - At bit end, stp_err is captured; go to IDLE.
- Frame result, registered and emitted in the cycle after the stop bit end:
  - data_valid = ~perr & ~serr.
  - par_error = perr.
  - frame_error = serr.
  - All three are 1-cycle pulses.
  - The internal error flags are cleared on START entry.
- Enables are Moore outputs decoded from the state register, except deser_en, which is gated by bit end.
- Prescale and PAR_EN are sampled only on the IDLE to START transition and held for the whole frame. A mid-frame change has no effect.
- Back-to-back frames: after STOP the FSM spends one cycle in IDLE. A start edge already present in that cycle is accepted there, costing one tick of start-bit alignment.
- Reset mid-frame: immediate return to IDLE. No data_valid or error pulse is emitted.
- RX_IN returning high during START is not acted on until bit end; strt_glitch governs the decision.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 sent LSB first, all checkers clean:
  - 8 deser_en pulses spaced 8 cycles apart.
  - data_valid=1 for one cycle exactly 80 cycles after the START entry (10 bits × 8).
  - No error pulses.
- Prescale=16, PAR_EN=1, par_err forced 1 during PARITY: par_error pulse, data_valid stays 0, 11×16 cycle frame.
- Prescale=32, stp_err=1 in STOP: frame_error pulse, data_valid=0. The next clean frame gives data_valid=1, confirming the flags were cleared.
- Start glitch with strt_glitch=1 at edge 7: FSM back in IDLE at cycle 8, no deser_en, no pulses.
- Prescale=5 (illegal): behaves exactly as Prescale=8. Prescale changed to 16 mid-frame: frame timing stays 8 per bit.
- RST low at bit_counter=4: all outputs 0 immediately. After release, a clean frame is received correctly.
